// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM transaction port among NUM_REQ requesters.
// Optional watchdog abort of stuck transactions: define SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter #(
  parameter int NUM_REQ        = 5,
  parameter int ADDR_W         = 23,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req_enable,
  input  logic [NUM_REQ-1:0]        i_req_read,
  input  logic [NUM_REQ-1:0]        i_req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_writedata,
  output logic [DATA_W-1:0]         o_req_readdata,
  output logic [NUM_REQ-1:0]        o_req_finished,
  output logic [2:0]                o_grant_id,
  output logic                      o_busy,
  output logic                      o_timeout,
  output logic                      sdram_read,
  output logic                      sdram_write,
  output logic [ADDR_W-1:0]         sdram_addr,
  output logic [DATA_W-1:0]         sdram_writedata,
  input  logic [DATA_W-1:0]         sdram_readdata,
  input  logic                      sdram_finished
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, GAP} state_t;

  state_t              state, next_state;
  logic [NUM_REQ-1:0]  pending;
  logic [7:0]          pend8;
  logic [NUM_REQ-1:0]  grant_onehot;
  logic [2:0]          last;
  logic [2:0]          pick;
  logic [3:0]          cand;
  logic                found;
  logic                do_grant;
  logic                finish_now;
  logic                abort_now;
  logic [ADDR_W-1:0]   req_addr  [NUM_REQ];
  logic [DATA_W-1:0]   req_wdata [NUM_REQ];

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("sdram_arbiter: parameter out of range");
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_addr[k]  = i_req_addr[k*ADDR_W +: ADDR_W];
    assign req_wdata[k] = i_req_writedata[k*DATA_W +: DATA_W];
  end

  assign pending      = i_req_enable & (i_req_read | i_req_write);
  assign pend8        = 8'(pending);
  assign grant_onehot = NUM_REQ'(1) << o_grant_id;
  assign o_busy       = (state != IDLE);

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    pick  = last;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = 4'(last) + 4'(i);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!found && pend8[cand[2:0]]) begin
        found = 1'b1;
        pick  = cand[2:0];
      end
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TIMER_W-1:0] timer;
  logic               expired;

  assign expired = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || state != BUSY) timer <= '0;
    else                        timer <= timer + TIMER_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) o_timeout <= 1'b0;
    else       o_timeout <= abort_now;
  end
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    do_grant   = 1'b0;
    finish_now = 1'b0;
    abort_now  = 1'b0;
    case (state)
      IDLE: if (found) begin
        next_state = BUSY;
        do_grant   = 1'b1;
      end
      BUSY: begin
        if (sdram_finished) begin
          next_state = DONE;
          finish_now = 1'b1;
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        else if (expired) begin
          next_state = GAP;
          abort_now  = 1'b1;
        end
`endif
      end
      DONE:    next_state = GAP;
      GAP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A simultaneous read+write is treated as a write; the read is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sdram_read      <= 1'b0;
      sdram_write     <= 1'b0;
      sdram_addr      <= '0;
      sdram_writedata <= '0;
      o_req_readdata  <= '0;
      o_req_finished  <= '0;
      o_grant_id      <= '0;
      last            <= 3'(NUM_REQ - 1);
    end else begin
      o_req_finished <= '0;
      if (do_grant) begin
        sdram_addr      <= req_addr[pick];
        sdram_writedata <= req_wdata[pick];
        sdram_write     <= i_req_write[pick];
        sdram_read      <= i_req_read[pick] & ~i_req_write[pick];
        o_grant_id      <= pick;
        last            <= pick;
      end
      if (finish_now) begin
        o_req_readdata <= sdram_read ? sdram_readdata : '0;
        sdram_read     <= 1'b0;
        sdram_write    <= 1'b0;
        o_req_finished <= grant_onehot;
      end
      if (abort_now) begin
        o_req_readdata <= '0;
        sdram_read     <= 1'b0;
        sdram_write    <= 1'b0;
        o_req_finished <= grant_onehot;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: SDRAM latency model plus completion scoreboard.
module tb_sdram_arbiter;
  localparam int NUM_REQ = 5;
  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 32;
  localparam int LAT     = 4;

  logic                      i_clk = 1'b0;
  logic                      i_rst;
  logic [NUM_REQ-1:0]        i_req_enable;
  logic [NUM_REQ-1:0]        i_req_read;
  logic [NUM_REQ-1:0]        i_req_write;
  logic [NUM_REQ*ADDR_W-1:0] i_req_addr;
  logic [NUM_REQ*DATA_W-1:0] i_req_writedata;
  logic [DATA_W-1:0]         o_req_readdata;
  logic [NUM_REQ-1:0]        o_req_finished;
  logic [2:0]                o_grant_id;
  logic                      o_busy;
  logic                      o_timeout;
  logic                      sdram_read;
  logic                      sdram_write;
  logic [ADDR_W-1:0]         sdram_addr;
  logic [DATA_W-1:0]         sdram_writedata;
  logic [DATA_W-1:0]         sdram_readdata = '0;
  logic                      sdram_finished = 1'b0;

  sdram_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(1024)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_enable(i_req_enable), .i_req_read(i_req_read), .i_req_write(i_req_write),
    .i_req_addr(i_req_addr), .i_req_writedata(i_req_writedata),
    .o_req_readdata(o_req_readdata), .o_req_finished(o_req_finished),
    .o_grant_id(o_grant_id), .o_busy(o_busy), .o_timeout(o_timeout),
    .sdram_read(sdram_read), .sdram_write(sdram_write), .sdram_addr(sdram_addr),
    .sdram_writedata(sdram_writedata), .sdram_readdata(sdram_readdata),
    .sdram_finished(sdram_finished)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0]        id;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   hang = 1'b0;
  bit   rr_active = 1'b0;
  int   lat_cnt = 0;
  int   cyc = 0;
  int   done_cyc = -1;
  logic op_prev = 1'b0;
  logic busy_prev = 1'b0;

  function automatic logic [DATA_W-1:0] model_data(input logic [ADDR_W-1:0] a);
    return (a == 23'h000100) ? 32'hDEADBEEF : {9'h0A5, a};
  endfunction

  // SDRAM side: finishes LAT cycles after an op appears, unless told to hang.
  always @(negedge i_clk) begin
    if (sdram_finished) begin
      sdram_finished = 1'b0;
      sdram_readdata = $urandom;
      lat_cnt = 0;
    end else if ((sdram_read || sdram_write) && !hang) begin
      lat_cnt++;
      if (lat_cnt == LAT) begin
        sdram_finished = 1'b1;
        sdram_readdata = model_data(sdram_addr);
      end
    end else begin
      lat_cnt = 0;
    end
  end

  // Scoreboard consumer and per-cycle protocol checks.
  always @(posedge i_clk) begin
    logic op_now;
    exp_t e;
    #1;
    cyc++;
    if (!rr_active) done_cyc = -1;
    op_now = sdram_read | sdram_write;
    if (op_now === 1'b1 && op_prev === 1'b0) begin
      checks++;
      if (busy_prev !== 1'b0) begin
        errors++;
        $display("[TB] FAIL grant_from_idle: busy before grant %b, required 0", busy_prev);
      end
      if (rr_active && done_cyc >= 0) begin
        checks++;
        if (cyc - done_cyc != 3) begin
          errors++;
          $display("[TB] FAIL rr_turnaround: %0d cycles done->grant, required 3", cyc - done_cyc);
        end
      end
    end
    if (|o_req_finished === 1'b1) begin
      checks++;
      if (sdram_finished !== 1'b1) begin
        errors++;
        $display("[TB] FAIL finish_latency: sdram_finished prev cycle %b, required 1", sdram_finished);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_finish: o_req_finished %b, required none", o_req_finished);
      end else begin
        e = sb.pop_front();
        if (o_req_finished !== (NUM_REQ'(1) << e.id) || o_req_readdata !== e.data || o_grant_id !== e.id) begin
          errors++;
          $display("[TB] FAIL completion: finished %b data %h id %0d, required %b data %h id %0d",
                   o_req_finished, o_req_readdata, o_grant_id, NUM_REQ'(1) << e.id, e.data, e.id);
        end
      end
      done_cyc = cyc;
    end else if (sdram_finished === 1'b1 && op_prev === 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL missing_finish: o_req_finished %b, required nonzero", o_req_finished);
    end
    op_prev   = op_now;
    busy_prev = o_busy;
  end

  task automatic wait_level(input int level, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(posedge i_clk); #2;
      if (sb.size() == level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_req_enable = '0;
    i_req_read = '0;
    i_req_write = '0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_req_enable = '1;
    i_req_read = '1;
    i_req_write = '1;
    i_req_addr = {4{$urandom}};
    i_req_writedata = {5{$urandom}};
    repeat (2) @(posedge i_clk);
    #1;
    checks++; if (sdram_read !== 1'b0) begin errors++; $display("[TB] FAIL reset_read: %b, required 0", sdram_read); end
    checks++; if (sdram_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_write: %b, required 0", sdram_write); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: %b, required 0", o_busy); end
    checks++; if (o_req_finished !== '0) begin errors++; $display("[TB] FAIL reset_finished: %b, required 0", o_req_finished); end
    checks++; if (o_req_readdata !== '0) begin errors++; $display("[TB] FAIL reset_readdata: %h, required 0", o_req_readdata); end
    checks++; if (o_grant_id !== 3'd0) begin errors++; $display("[TB] FAIL reset_grant: %0d, required 0", o_grant_id); end
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: %b, required 0", o_timeout); end
    checks++; if (sdram_addr !== '0 || sdram_writedata !== '0) begin errors++; $display("[TB] FAIL reset_bus: addr %h wdata %h, required 0", sdram_addr, sdram_writedata); end
    i_req_enable = '0;
    i_req_read = '0;
    i_req_write = '0;
    i_req_addr = '0;
    i_req_writedata = '0;
    i_rst = 1'b0;
  endtask

  task automatic test_single_read();
    bit ok;
    settle();
    i_req_enable = '1;
    i_req_addr[2*ADDR_W +: ADDR_W] = 23'h000100;
    i_req_read[2] = 1'b1;
    sb.push_back(exp_t'{id: 3'd2, data: 32'hDEADBEEF});
    @(posedge i_clk); #1;
    checks++;
    if (sdram_read !== 1'b1 || sdram_write !== 1'b0 || sdram_addr !== 23'h000100 || o_grant_id !== 3'd2) begin
      errors++;
      $display("[TB] FAIL single_issue: rd %b wr %b addr %h id %0d, required 1 0 000100 2", sdram_read, sdram_write, sdram_addr, o_grant_id);
    end
    wait_level(0, 50, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL single_timeout: pending %0d, required 0", sb.size()); end
    i_req_read[2] = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    checks++;
    if (o_req_readdata !== 32'hDEADBEEF || o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_hold: data %h busy %b, required deadbeef 0", o_req_readdata, o_busy);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int ids [3] = '{0, 1, 3};
    do_reset();
    rr_active = 1'b1;
    i_req_addr[0*ADDR_W +: ADDR_W] = 23'h000040;
    i_req_addr[1*ADDR_W +: ADDR_W] = 23'h000041;
    i_req_addr[3*ADDR_W +: ADDR_W] = 23'h000043;
    for (int r = 0; r < 2; r++)
      foreach (ids[j])
        sb.push_back(exp_t'{id: 3'(ids[j]), data: model_data(23'h000040 + 23'(ids[j]))});
    i_req_enable = '1;
    i_req_read = 5'b01011;
    wait_level(0, 200, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rr_timeout: pending %0d, required 0", sb.size()); end
    i_req_read = '0;
    repeat (4) @(posedge i_clk);
    #1;
    rr_active = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL rr_extra_grant: busy %b, required 0", o_busy); end
  endtask

  task automatic test_read_write_both();
    bit ok;
    bit saw_read;
    settle();
    i_req_enable = '1;
    i_req_addr[1*ADDR_W +: ADDR_W] = 23'h00002A;
    i_req_writedata[1*DATA_W +: DATA_W] = 32'h12345678;
    i_req_read[1] = 1'b1;
    i_req_write[1] = 1'b1;
    sb.push_back(exp_t'{id: 3'd1, data: '0});
    @(posedge i_clk); #1;
    checks++;
    if (sdram_write !== 1'b1 || sdram_read !== 1'b0 || sdram_writedata !== 32'h12345678 || sdram_addr !== 23'h00002A) begin
      errors++;
      $display("[TB] FAIL rw_issue: wr %b rd %b wdata %h addr %h, required 1 0 12345678 00002a", sdram_write, sdram_read, sdram_writedata, sdram_addr);
    end
    ok = 1'b0;
    saw_read = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(posedge i_clk); #2;
      if (sdram_read !== 1'b0) saw_read = 1'b1;
      if (sb.size() == 0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rw_timeout: pending %0d, required 0", sb.size()); end
    checks++; if (saw_read) begin errors++; $display("[TB] FAIL rw_read_seen: sdram_read 1, required 0"); end
    i_req_read[1] = 1'b0;
    i_req_write[1] = 1'b0;
  endtask

  task automatic test_enable_mask();
    bit ok;
    settle();
    i_req_enable = 5'b11101;
    i_req_addr[1*ADDR_W +: ADDR_W] = 23'h000077;
    i_req_read[1] = 1'b1;
    repeat (5) begin
      @(posedge i_clk); #1;
      checks++;
      if (o_busy !== 1'b0 || sdram_read !== 1'b0) begin
        errors++;
        $display("[TB] FAIL masked_grant: busy %b rd %b, required 0 0", o_busy, sdram_read);
      end
    end
    i_req_enable = 5'b11111;
    sb.push_back(exp_t'{id: 3'd1, data: model_data(23'h000077)});
    @(posedge i_clk); #1;
    checks++;
    if (sdram_read !== 1'b1 || o_grant_id !== 3'd1) begin
      errors++;
      $display("[TB] FAIL unmask_grant: rd %b id %0d, required 1 1", sdram_read, o_grant_id);
    end
    wait_level(0, 50, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL mask_timeout: pending %0d, required 0", sb.size()); end
    i_req_read[1] = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    bit ok;
    settle();
    hang = 1'b1;
    i_req_enable = '1;
    i_req_addr[2*ADDR_W +: ADDR_W] = 23'h000055;
    i_req_read[2] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge i_clk); #1;
      if (sdram_read === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("[TB] FAIL hung_issue: sdram_read %b, required 1", sdram_read); end
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    i_req_addr[0*ADDR_W +: ADDR_W] = 23'h000040;
    i_req_read = 5'b00101;
    @(posedge i_clk); #1;
    checks++; if (sdram_read !== 1'b0 || sdram_write !== 1'b0) begin errors++; $display("[TB] FAIL abort_bus: rd %b wr %b, required 0 0", sdram_read, sdram_write); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: %b, required 0", o_busy); end
    checks++; if (o_req_finished !== '0 || o_req_readdata !== '0) begin errors++; $display("[TB] FAIL abort_finish: fin %b data %h, required 0 0", o_req_finished, o_req_readdata); end
    i_rst = 1'b0;
    hang = 1'b0;
    sb.push_back(exp_t'{id: 3'd0, data: model_data(23'h000040)});
    sb.push_back(exp_t'{id: 3'd2, data: model_data(23'h000055)});
    @(posedge i_clk); #1;
    checks++;
    if (sdram_read !== 1'b1 || o_grant_id !== 3'd0 || sdram_addr !== 23'h000040) begin
      errors++;
      $display("[TB] FAIL post_reset_grant: rd %b id %0d addr %h, required 1 0 000040", sdram_read, o_grant_id, sdram_addr);
    end
    wait_level(1, 50, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL post_reset_first: pending %0d, required 1", sb.size()); end
    i_req_read[0] = 1'b0;
    wait_level(0, 50, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL post_reset_second: pending %0d, required 0", sb.size()); end
    i_req_read[2] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_read_write_both();
    test_enable_mask();
    test_reset_mid_busy();
    repeat (5) @(posedge i_clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL leftover_expected: %0d entries, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
